// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like slave: transfer size codes and the
// byte-lane strobe derived from size and the low address bits.
package sram_like_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  // Wide enough for a wait count of LATENCY-2 with LATENCY up to 9.
  localparam int CNT_W = 3;

  // A half-word at offset 3 keeps only lane 3; word transfers ignore the offset.
  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] offs);
    logic [3:0] s;
    case (size_e'(size))
      SZ_BYTE: s = 4'b0001 << offs;
      SZ_HALF: s = 4'b0011 << offs;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sram_like_slave_req_fifo.sv
// Pending-request queue: each entry carries a wait counter that counts down
// every cycle wherever it sits, so the head is ready as soon as its count hits 0.
module req_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic [CNT_W-1:0]           push_cnt_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_data_o,
  output logic                       head_ready_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0]    PTR_ONE = 1;
  localparam logic [CW-1:0]    CNT_ONE = 1;
  localparam logic [CNT_W-1:0] WAIT_ONE = 1;

  logic [W-1:0]     data_q [DEPTH];
  logic [CNT_W-1:0] wait_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // On a full push/pop the write slot equals the slot being popped, so the
  // push assignment below must win over the countdown.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wait_q[PW'(i)] != '0) wait_q[PW'(i)] <= wait_q[PW'(i)] - WAIT_ONE;
    end
    if (push_i) begin
      data_q[wr_ptr_q] <= push_data_i;
      wait_q[wr_ptr_q] <= push_cnt_i;
    end
  end

  assign head_data_o  = data_q[rd_ptr_q];
  assign head_ready_o = (count_q != '0) && (wait_q[rd_ptr_q] == '0);
  assign count_o      = count_q;

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like slave: queues accepted requests, issues each to the SRAM after a
// fixed wait and returns a one-cycle data_ok the cycle after the access.
module sram_like_slave
  import sram_like_pkg::*;
#(
  parameter int MEM_AW  = 16,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [MEM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int W  = 1 + 4 + 32 + MEM_AW;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] INIT_WAIT = CNT_W'(LATENCY - 2);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);

  logic [CW-1:0]     count;
  logic              issue;
  logic [W-1:0]      push_data;
  logic [W-1:0]      head;
  logic              h_wr;
  logic [3:0]        h_strb;
  logic [31:0]       h_wdata;
  logic [MEM_AW-1:0] h_addr;
  logic              data_ok_q;
  logic              rd_q;
  logic              unused_addr_hi;

  // Handshake: a request transfers in any cycle where req and addr_ok are both
  // high; the initiator holds its request until then. data_ok has no backpressure.
  assign addr_ok   = aresetn && req && ((count < DEPTH_C) || issue);
  assign push_data = {wr, byte_strobe(size, addr[1:0]), wdata, addr[MEM_AW+1:2]};

  req_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_req_fifo (
    .clk          (aclk),
    .rst_n        (aresetn),
    .push_i       (addr_ok),
    .push_data_i  (push_data),
    .push_cnt_i   (INIT_WAIT),
    .pop_i        (issue),
    .head_data_o  (head),
    .head_ready_o (issue),
    .count_o      (count)
  );

  assign {h_wr, h_strb, h_wdata, h_addr} = head;

  assign ram_en    = issue;
  assign ram_wen   = (issue && h_wr) ? h_strb : 4'b0000;
  assign ram_addr  = issue ? h_addr : '0;
  assign ram_wdata = issue ? h_wdata : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_ok_q <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      data_ok_q <= issue;
      rd_q      <= issue && !h_wr;
    end
  end

  // The SRAM answers one cycle after ram_en, which is exactly the data_ok cycle.
  assign data_ok = data_ok_q;
  assign rdata   = (data_ok_q && rd_q) ? ram_rdata : 32'h0;

  assign unused_addr_hi = ^addr[31:MEM_AW+2];

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench: instance A (LATENCY=2) runs a vector table, instance B
// (LATENCY=4) covers the stall, ordering and mid-operation reset sequences.
module tb_sram_like_slave;

  typedef struct {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_aok;
    logic        e_en;
    logic [3:0]  e_wen;
    logic [15:0] e_raddr;
    logic [31:0] e_rwdata;
    logic        e_dok;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 25;

  logic clk;
  logic aresetn;

  logic        a_req, a_wr, a_addr_ok, a_data_ok, a_ram_en;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rdata, a_ram_wdata, a_ram_rdata;
  logic [3:0]  a_ram_wen;
  logic [15:0] a_ram_addr;

  logic        b_req, b_wr, b_addr_ok, b_data_ok, b_ram_en;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata, b_ram_wdata, b_ram_rdata;
  logic [3:0]  b_ram_wen;
  logic [15:0] b_ram_addr;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] exp_q [$];
  vec_t        vecs [NV];
  int          n_checks;
  int          n_errors;

  sram_like_slave #(.MEM_AW(16), .LATENCY(2), .DEPTH(2)) dut_a (
    .aclk(clk), .aresetn(aresetn), .req(a_req), .wr(a_wr), .size(a_size),
    .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .addr_ok(a_addr_ok),
    .data_ok(a_data_ok), .ram_en(a_ram_en), .ram_wen(a_ram_wen),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
  );

  sram_like_slave #(.MEM_AW(16), .LATENCY(4), .DEPTH(2)) dut_b (
    .aclk(clk), .aresetn(aresetn), .req(b_req), .wr(b_wr), .size(b_size),
    .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .addr_ok(b_addr_ok),
    .data_ok(b_data_ok), .ram_en(b_ram_en), .ram_wen(b_ram_wen),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // SRAM models: one-cycle read latency, byte-lane writes, reloaded during reset.
  always @(posedge clk) begin
    if (!aresetn) begin
      for (int i = 0; i < 256; i++) mem_a[8'(i)] <= init_word(i);
      a_ram_rdata <= 32'h0;
    end else if (a_ram_en) begin
      a_ram_rdata <= mem_a[a_ram_addr[7:0]];
      for (int j = 0; j < 4; j++)
        if (a_ram_wen[j]) mem_a[a_ram_addr[7:0]][8*j +: 8] <= a_ram_wdata[8*j +: 8];
    end
  end

  always @(posedge clk) begin
    if (!aresetn) begin
      for (int i = 0; i < 256; i++) mem_b[8'(i)] <= init_word(i);
      b_ram_rdata <= 32'h0;
    end else if (b_ram_en) begin
      b_ram_rdata <= mem_b[b_ram_addr[7:0]];
      for (int j = 0; j < 4; j++)
        if (b_ram_wen[j]) mem_b[b_ram_addr[7:0]][8*j +: 8] <= b_ram_wdata[8*j +: 8];
    end
  end

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic req, input logic wr, input logic [1:0] sz,
                             input logic [31:0] ad, input logic [31:0] wd,
                             input logic aok, input logic en, input logic [3:0] wen,
                             input logic [15:0] ra, input logic [31:0] rw,
                             input logic dok, input logic [31:0] rd);
    vec_t r;
    r.req = req; r.wr = wr; r.size = sz; r.addr = ad; r.wdata = wd;
    r.e_aok = aok; r.e_en = en; r.e_wen = wen; r.e_raddr = ra;
    r.e_rwdata = rw; r.e_dok = dok; r.e_rdata = rd;
    return r;
  endfunction

  // Driver tasks
  task automatic drive_a(input vec_t x);
    a_req = x.req; a_wr = x.wr; a_size = x.size; a_addr = x.addr; a_wdata = x.wdata;
  endtask

  task automatic drive_b(input logic req, input logic [31:0] ad);
    b_req = req; b_wr = 1'b0; b_size = 2'd2; b_addr = ad; b_wdata = 32'h0;
  endtask

  task automatic chk_b_zero(input string tag);
    chk({tag, " b addr_ok"},   32'(b_addr_ok),   32'h0);
    chk({tag, " b data_ok"},   32'(b_data_ok),   32'h0);
    chk({tag, " b rdata"},     b_rdata,          32'h0);
    chk({tag, " b ram_en"},    32'(b_ram_en),    32'h0);
    chk({tag, " b ram_wen"},   32'(b_ram_wen),   32'h0);
    chk({tag, " b ram_addr"},  32'(b_ram_addr),  32'h0);
    chk({tag, " b ram_wdata"}, b_ram_wdata,      32'h0);
  endtask

  initial begin
    logic [13:0] aok_exp;
    logic [13:0] dok_exp;
    int nxt;

    n_checks = 0;
    n_errors = 0;
    nxt      = 0;
    aok_exp  = 14'b00000011011011;
    dok_exp  = 14'b00110110110000;

    //        req   wr    size  addr          wdata          aok   en    wen      raddr    rwdata         dok   rdata
    vecs[0]  = v(1'b1, 1'b0, 2'd2, 32'h100,  32'h0,        1'b1, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b0, 32'h0);
    vecs[1]  = v(1'b1, 1'b1, 2'd0, 32'h103,  32'hAA000000, 1'b1, 1'b1, 4'b0000, 16'h40, 32'h0,        1'b0, 32'h0);
    vecs[2]  = v(1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b0, 1'b1, 4'b1000, 16'h40, 32'hAA000000, 1'b1, 32'hC0DE0040);
    vecs[3]  = v(1'b1, 1'b0, 2'd2, 32'h100,  32'h0,        1'b1, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b1, 32'h0);
    vecs[4]  = v(1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b0, 1'b1, 4'b0000, 16'h40, 32'h0,        1'b0, 32'h0);
    vecs[5]  = v(1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b0, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b1, 32'hAADE0040);
    vecs[6]  = v(1'b1, 1'b0, 2'd2, 32'h0,    32'h0,        1'b1, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b0, 32'h0);
    vecs[7]  = v(1'b1, 1'b0, 2'd2, 32'h4,    32'h0,        1'b1, 1'b1, 4'b0000, 16'h0,  32'h0,        1'b0, 32'h0);
    vecs[8]  = v(1'b1, 1'b0, 2'd2, 32'h8,    32'h0,        1'b1, 1'b1, 4'b0000, 16'h1,  32'h0,        1'b1, 32'hC0DE0000);
    vecs[9]  = v(1'b1, 1'b0, 2'd2, 32'hC,    32'h0,        1'b1, 1'b1, 4'b0000, 16'h2,  32'h0,        1'b1, 32'hC0DE0001);
    vecs[10] = v(1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b0, 1'b1, 4'b0000, 16'h3,  32'h0,        1'b1, 32'hC0DE0002);
    vecs[11] = v(1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b0, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b1, 32'hC0DE0003);
    vecs[12] = v(1'b1, 1'b1, 2'd1, 32'h3,    32'h12000000, 1'b1, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b0, 32'h0);
    vecs[13] = v(1'b1, 1'b1, 2'd3, 32'h2,    32'h55667788, 1'b1, 1'b1, 4'b1000, 16'h0,  32'h12000000, 1'b0, 32'h0);
    vecs[14] = v(1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b0, 1'b1, 4'b1111, 16'h0,  32'h55667788, 1'b1, 32'h0);
    vecs[15] = v(1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b0, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b1, 32'h0);
    vecs[16] = v(1'b1, 1'b1, 2'd0, 32'h5,    32'h0000BB00, 1'b1, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b0, 32'h0);
    vecs[17] = v(1'b1, 1'b0, 2'd1, 32'h6,    32'h0,        1'b1, 1'b1, 4'b0010, 16'h1,  32'h0000BB00, 1'b0, 32'h0);
    vecs[18] = v(1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b0, 1'b1, 4'b0000, 16'h1,  32'h0,        1'b1, 32'h0);
    vecs[19] = v(1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b0, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b1, 32'hC0DEBB01);
    vecs[20] = v(1'b0, 1'b1, 2'd3, 32'hFFFC, 32'hDEADBEEF, 1'b0, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b0, 32'h0);
    vecs[21] = v(1'b0, 1'b1, 2'd0, 32'h8,    32'h1,        1'b0, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b0, 32'h0);
    vecs[22] = v(1'b1, 1'b0, 2'd2, 32'h0,    32'h0,        1'b1, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b0, 32'h0);
    vecs[23] = v(1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b0, 1'b1, 4'b0000, 16'h0,  32'h0,        1'b0, 32'h0);
    vecs[24] = v(1'b0, 1'b0, 2'd0, 32'h0,    32'h0,        1'b0, 1'b0, 4'b0000, 16'h0,  32'h0,        1'b1, 32'h55667788);

    // Reset: outputs must stay quiet even with requests presented.
    aresetn = 1'b0;
    drive_a(vecs[0]);
    drive_b(1'b1, 32'h40);
    repeat (3) @(negedge clk);
    #1;
    chk("reset a addr_ok",   32'(a_addr_ok),  32'h0);
    chk("reset a data_ok",   32'(a_data_ok),  32'h0);
    chk("reset a rdata",     a_rdata,         32'h0);
    chk("reset a ram_en",    32'(a_ram_en),   32'h0);
    chk("reset a ram_wen",   32'(a_ram_wen),  32'h0);
    chk("reset a ram_addr",  32'(a_ram_addr), 32'h0);
    chk("reset a ram_wdata", a_ram_wdata,     32'h0);
    chk_b_zero("reset");
    drive_b(1'b0, 32'h0);

    // Vector table on instance A; the first vector follows reset release.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i == 0) aresetn = 1'b1;
      drive_a(vecs[i]);
      #1;
      chk($sformatf("vec%0d addr_ok", i),   32'(a_addr_ok),  32'(vecs[i].e_aok));
      chk($sformatf("vec%0d ram_en", i),    32'(a_ram_en),   32'(vecs[i].e_en));
      chk($sformatf("vec%0d ram_wen", i),   32'(a_ram_wen),  32'(vecs[i].e_wen));
      chk($sformatf("vec%0d ram_addr", i),  32'(a_ram_addr), 32'(vecs[i].e_raddr));
      chk($sformatf("vec%0d ram_wdata", i), a_ram_wdata,     vecs[i].e_rwdata);
      chk($sformatf("vec%0d data_ok", i),   32'(a_data_ok),  32'(vecs[i].e_dok));
      chk($sformatf("vec%0d rdata", i),     a_rdata,         vecs[i].e_rdata);
    end
    a_req = 1'b0;

    // Instance B, request held high for 8 cycles into a 2-deep queue.
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      drive_b(c < 8, 32'(nxt) * 32'd4);
      #1;
      chk($sformatf("stall c%0d addr_ok", c), 32'(b_addr_ok), 32'(aok_exp[c]));
      chk($sformatf("stall c%0d data_ok", c), 32'(b_data_ok), 32'(dok_exp[c]));
      if (b_data_ok) begin
        if (exp_q.size() > 0) begin
          chk($sformatf("stall c%0d rdata", c), b_rdata, exp_q.pop_front());
        end else begin
          n_checks++;
          n_errors++;
          $display("FAIL stall c%0d extra data_ok: got rdata %h expected no completion", c, b_rdata);
        end
      end
      if (aok_exp[c]) begin
        exp_q.push_back(init_word(nxt));
        nxt++;
      end
    end
    chk("stall drained", 32'(exp_q.size()), 32'h0);

    // Mid-operation reset on B with two requests pending and one issuing.
    @(negedge clk); drive_b(1'b1, 32'h20); #1;
    chk("rst pend0 addr_ok", 32'(b_addr_ok), 32'h1);
    @(negedge clk); drive_b(1'b1, 32'h24); #1;
    chk("rst pend1 addr_ok", 32'(b_addr_ok), 32'h1);
    @(negedge clk); drive_b(1'b0, 32'h0); #1;
    chk("rst wait ram_en", 32'(b_ram_en), 32'h0);
    @(negedge clk); drive_b(1'b1, 32'h28); #1;
    chk("rst issue ram_en",   32'(b_ram_en),   32'h1);
    chk("rst issue ram_addr", 32'(b_ram_addr), 32'h8);
    chk("rst full addr_ok",   32'(b_addr_ok),  32'h1);
    #1 aresetn = 1'b0;
    #1;
    chk_b_zero("async rst");
    chk("async rst a ram_en", 32'(a_ram_en), 32'h0);
    @(negedge clk); drive_b(1'b0, 32'h0);
    @(negedge clk); aresetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      chk($sformatf("post rst %0d data_ok", k), 32'(b_data_ok), 32'h0);
      chk($sformatf("post rst %0d ram_en", k),  32'(b_ram_en),  32'h0);
    end
    @(negedge clk); drive_b(1'b1, 32'h14); #1;
    chk("post rst accept", 32'(b_addr_ok), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); drive_b(1'b0, 32'h0); #1;
      chk($sformatf("post rst T+%0d data_ok", k), 32'(b_data_ok), 32'(k == 4));
      if (k == 4) chk("post rst rdata", b_rdata, 32'hC0DE0005);
    end

    // Report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
